// File: rtl/ehgu_clkgate_pkg.sv
// Shared types and width helpers for the ehgu clock-gate enable controller.
package ehgu_clkgate_pkg;

  typedef enum logic [1:0] {ST_WAKE, ST_ON, ST_SREQ, ST_OFF} cg_state_e;

  // A counter that must hold the value n needs $clog2(n+1) bits, never fewer than 1.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ehgu_clkgate_ctrl.sv
// Enable controller for ehgu_clkgate: idle detection, sleep handshake, wake
// sequencing and a saturating gate-event counter. All outputs are registered.
module ehgu_clkgate_ctrl
  import ehgu_clkgate_pkg::*;
#(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             busy,
  input  logic             wake_req,
  input  logic             force_on,
  input  logic             sleep_ack,
  output logic             clken,
  output logic             sleep_req,
  output logic             clk_ready,
  output logic             gated,
  output logic [CNT_W-1:0] gate_events
);

  localparam int IDLE_W = cnt_width(IDLE_CYCLES);
  localparam int WAKE_W = cnt_width(WAKE_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  cg_state_e         state, state_n;
  logic [IDLE_W-1:0] idle_cnt, idle_n;
  logic [WAKE_W-1:0] wake_cnt, wake_n;
  logic [CNT_W-1:0]  events_n;
  logic              quiet;

  assign quiet = !busy && !wake_req && !force_on;

  always_comb begin
    state_n  = state;
    idle_n   = '0;
    wake_n   = '0;
    events_n = gate_events;
    unique case (state)
      ST_WAKE: begin
        wake_n = wake_cnt + WAKE_W'(1);
        if (wake_cnt == WAKE_LAST) begin
          state_n = ST_ON;
          wake_n  = '0;
        end
      end
      ST_ON: begin
        if (quiet) begin
          if (idle_cnt == IDLE_LAST) state_n = ST_SREQ;
          else                       idle_n  = idle_cnt + IDLE_W'(1);
        end
      end
      ST_SREQ: begin
        // Any activity aborts the request, even if the ack lands the same cycle.
        if (!quiet) begin
          state_n = ST_ON;
        end else if (sleep_ack) begin
          state_n  = ST_OFF;
          events_n = (&gate_events) ? gate_events : gate_events + CNT_W'(1);
        end
      end
      ST_OFF: begin
        if (wake_req || force_on) state_n = ST_WAKE;
      end
      default: state_n = ST_WAKE;
    endcase
  end

  // Outputs are decoded from the next state so each one is a plain flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_WAKE;
      idle_cnt    <= '0;
      wake_cnt    <= '0;
      clken       <= 1'b1;
      sleep_req   <= 1'b0;
      clk_ready   <= 1'b0;
      gated       <= 1'b0;
      gate_events <= '0;
    end else begin
      state       <= state_n;
      idle_cnt    <= idle_n;
      wake_cnt    <= wake_n;
      clken       <= (state_n != ST_OFF);
      sleep_req   <= (state_n == ST_SREQ);
      clk_ready   <= (state_n == ST_ON) || (state_n == ST_SREQ);
      gated       <= (state_n == ST_OFF);
      gate_events <= events_n;
    end
  end

  a_ready_en: assert property (@(posedge clk) disable iff (!rst_n) clk_ready |-> clken);
  a_gated:    assert property (@(posedge clk) disable iff (!rst_n) gated == !clken);
  a_sreq_en:  assert property (@(posedge clk) disable iff (!rst_n) sleep_req |-> clken);

endmodule
